// File: rtl/audio_pkg.sv
// audio_pkg: shared volume/mode encodings and the sign-preserving scale helper
package audio_pkg;

    localparam logic [1:0] VOL_MUTE = 2'd0;
    localparam logic [1:0] VOL_QTR  = 2'd1;
    localparam logic [1:0] VOL_HALF = 2'd2;
    localparam logic [1:0] VOL_FULL = 2'd3;

    localparam logic MODE_LJ  = 1'b0;
    localparam logic MODE_I2S = 1'b1;

    function automatic logic signed [31:0] ashr(input logic signed [31:0] x, input int sh);
        return x >>> sh;
    endfunction

endpackage

// File: rtl/audio_sample_proc.sv
// audio_sample_proc: width conversion, mono mix, volume and attenuation in one register stage
module audio_sample_proc
    import audio_pkg::*;
#(
    parameter int IN_W      = 18,
    parameter int DATA_W    = 16,
    parameter int STEREO    = 1,
    parameter int ATT_SHIFT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        volume,
    input  logic [IN_W-1:0]   audio_l,
    input  logic [IN_W-1:0]   audio_r,
    output logic [DATA_W-1:0] left,
    output logic [DATA_W-1:0] right
);

    logic signed [DATA_W-1:0] l_cv, r_cv, mono, l_sel, r_sel, l_fin, r_fin;
    logic signed [DATA_W:0]   sum;
    int                       vol_sh;

    // drop LSBs, optionally average the channels (one extra bit keeps the sum exact), then scale
    always_comb begin
        l_cv   = DATA_W'($signed(audio_l) >>> (IN_W - DATA_W));
        r_cv   = DATA_W'($signed(audio_r) >>> (IN_W - DATA_W));
        sum    = (DATA_W+1)'(l_cv) + (DATA_W+1)'(r_cv);
        mono   = DATA_W'(sum >>> 1);
        l_sel  = (STEREO != 0) ? l_cv : mono;
        r_sel  = (STEREO != 0) ? r_cv : mono;
        vol_sh = (volume == VOL_FULL) ? 0 : (volume == VOL_HALF) ? 1 : (volume == VOL_QTR) ? 2 : 0;
        l_fin  = DATA_W'(ashr(ashr(32'(l_sel), vol_sh), ATT_SHIFT));
        r_fin  = DATA_W'(ashr(ashr(32'(r_sel), vol_sh), ATT_SHIFT));
    end

    // pipeline register; mute overrides the scaled value
    always_ff @(posedge clk) begin
        if (reset) begin
            left  <= '0;
            right <= '0;
        end else begin
            left  <= (volume == VOL_MUTE) ? '0 : l_fin;
            right <= (volume == VOL_MUTE) ? '0 : r_fin;
        end
    end

endmodule

// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx: clock-enable bit clock divider and L/R frame serializer for I2S / left-justified DACs
module i2s_audio_tx
    import audio_pkg::*;
#(
    parameter int IN_W      = 18,
    parameter int DATA_W    = 16,
    parameter int STEREO    = 1,
    parameter int ATT_SHIFT = 0,
    parameter int DIV_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             i2s_mode,
    input  logic [1:0]       volume,
    input  logic [IN_W-1:0]  audio_l,
    input  logic [IN_W-1:0]  audio_r,
    output logic             bck,
    output logic             ws,
    output logic             din,
    output logic             frame_strobe
);

    localparam int             FW   = 2 * DATA_W;
    localparam int             BW   = $clog2(FW);
    localparam logic [BW-1:0]  LAST = BW'(FW - 1);
    localparam logic [BW-1:0]  HALF = BW'(DATA_W);

    logic [DIV_W-1:0]  cnt;
    logic [BW-1:0]     bit_cnt, bit_nxt, bit_ahead;
    logic [FW-1:0]     shreg;
    logic [DATA_W-1:0] left, right;
    logic              tick, fall, wrap;

    audio_sample_proc #(
        .IN_W     (IN_W),
        .DATA_W   (DATA_W),
        .STEREO   (STEREO),
        .ATT_SHIFT(ATT_SHIFT)
    ) u_proc (
        .clk    (clk),
        .reset  (reset),
        .volume (volume),
        .audio_l(audio_l),
        .audio_r(audio_r),
        .left   (left),
        .right  (right)
    );

    // divider terminal count, falling event, next slot and the slot one bck ahead (I2S word select lead)
    always_comb begin
        tick      = cnt >= clk_div;
        fall      = bck && tick;
        wrap      = bit_cnt == LAST;
        bit_nxt   = wrap ? '0 : bit_cnt + BW'(1);
        bit_ahead = (bit_nxt == LAST) ? '0 : bit_nxt + BW'(1);
    end

    // bck divider plus serializer; a new L/R pair is latched whenever the slot counter wraps
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            bck          <= 1'b0;
            bit_cnt      <= LAST;
            shreg        <= '0;
            ws           <= 1'b0;
            din          <= 1'b0;
            frame_strobe <= 1'b0;
        end else begin
            cnt          <= tick ? '0 : cnt + DIV_W'(1);
            bck          <= tick ? ~bck : bck;
            frame_strobe <= fall && wrap;
            if (fall) begin
                bit_cnt <= bit_nxt;
                shreg   <= wrap ? {left, right} : shreg << 1;
                din     <= wrap ? left[DATA_W-1] : shreg[FW-2];
                ws      <= (i2s_mode == MODE_LJ) ? (bit_nxt >= HALF) : (bit_ahead >= HALF);
            end
        end
    end

endmodule

// File: doc/i2s_audio_tx.md
Name: i2s_audio_tx

Overview:
Parametrised I2S/left-justified audio serializer for the C64Nano console targets. It supersedes the ad-hoc I2S logic that lived inside the video/HDMI glue.
- Runs entirely in the `clk` domain: bit clock is a clock-enable divider, with no derived clock net.
- Converts core audio of width IN_W to DATA_W, with optional mono mix, 4-step volume and fixed amplifier attenuation.
- Latches one L/R pair per frame and drives bck/ws/din to the on-board DAC/amplifier.

Parameters:
IN_W, 18, width of signed input samples.
DATA_W, 16, width of each serialized channel slot; requires IN_W >= DATA_W.
STEREO, 1, 1 = independent L/R; 0 = (L+R)/2 sent on both slots.
ATT_SHIFT, 0, extra arithmetic right shift applied after volume (amplifier headroom; TN20k uses 1).
DIV_W, 8, width of clk_div.

Ports:
clk  in  1  system/pixel clock.
reset  in  1  synchronous, active-high reset.
clk_div  in  DIV_W  bck half-period minus one, in clk cycles.
i2s_mode  in  1  0 = left-justified, 1 = Philips I2S (ws leads data by one bck).
volume  in  2  0 = mute, 1 = 1/4, 2 = 1/2, 3 = full.
audio_l  in  IN_W  signed left sample; sampled every clk.
audio_r  in  IN_W  signed right sample; sampled every clk.
bck  out  1  serial bit clock.
ws  out  1  word select; 0 = left slot.
din  out  1  serial data, MSB first.
frame_strobe  out  1  one-clk pulse when a new L/R pair is latched.

Behaviour:
Reset values:
- bck = 0, ws = 0, din = 0, frame_strobe = 0.
- Divider count = 0; bit_cnt = 2*DATA_W-1; shift registers = 0; pipeline registers = 0.

Sample pipeline (one register stage, always running):
- Stage 1: conversion to DATA_W = arithmetic shift right by IN_W-DATA_W.
- Stage 1, STEREO=0 only: the mono mix is computed in the same stage. L and R are summed at DATA_W+1 bits and shifted right arithmetically by 1. This cannot overflow.
- Volume: 0 forces zero; 1 = >>>2; 2 = >>>1; 3 = pass-through.
- After volume: >>>ATT_SHIFT.
- All shifts are arithmetic (sign-preserving).

Divider:
- When cnt >= clk_div: cnt <= 0 and bck toggles. Otherwise cnt increments.
- The >= comparison makes a mid-run decrease of clk_div take effect on the next clk with no lock-up.
- clk_div = 0 gives bck = clk/2.

Falling event = the clk on which bck goes 1 -> 0. On each falling event:
- bit_cnt <= (bit_cnt == 2*DATA_W-1) ? 0 : bit_cnt+1.
- On wrap to 0: the current pipeline L/R outputs are copied into the frame shift register, and frame_strobe = 1 for that clk only.
- ws and din update on the same clk as the falling event.

Slot mapping:
- Slot index s = bit_cnt.
- din = left[DATA_W-1-s] for s < DATA_W; otherwise right[2*DATA_W-1-s].
- i2s_mode = 0: ws = (s >= DATA_W).
- i2s_mode = 1: ws = (((s+1) mod 2*DATA_W) >= DATA_W). ws therefore changes one bck before the MSB of each slot.
- The receiver samples on rising bck. All outputs are registered, so din and ws are stable for a full bck half-period before each rising edge.

Boundary conditions:
- First frame after reset: the first falling event wraps bit_cnt to 0 and latches immediately. No zero-frame is emitted.
- Input changes mid-frame do not affect the frame in flight.
- volume and i2s_mode changes take effect no earlier than the next falling event. Volume is latched with the next frame.
- Reset asserted mid-frame returns all state to reset values on the next clk.

Decomposition:
- Shared package audio_pkg:
  - Volume encoding constants (VOL_MUTE, VOL_QTR, VOL_HALF, VOL_FULL).
  - Mode constants (MODE_LJ, MODE_I2S).
  - A helper function for arithmetic scale-by-shift.
- One sub-module is natural: audio_sample_proc. It covers width conversion, mono mix, volume and attenuation, with one register stage.
- The serializer, divider and framing stay in i2s_audio_tx.

Test Plan:
All scenarios use defaults unless stated; clk_div = 3, i2s_mode = 0, volume = 3.
1. Reset release, audio_l = 18'h12344, audio_r = 18'h3FFFC:
   - bck period = 8 clk; frame = 256 clk.
   - First frame: left slot serializes 16'h48D1 MSB first; right slot serializes 16'hFFFF.
   - ws = 0 for 16 bck, then 1 for 16 bck.
   - frame_strobe pulses once per 256 clk.
2. Same inputs, volume = 1, then 2:
   - Left slot = 16'h1234 at volume 1, then 16'h2468 at volume 2.
   - Right slot stays 16'hFFFF.
   - volume = 0 -> both slots 16'h0000.
3. STEREO = 0, same inputs: both slots = 16'h2468.
4. i2s_mode = 1: ws falls one bck before the left MSB and rises one bck before the right MSB. din bit sequence is identical to scenario 1.
5. Change audio_l mid-left-slot: the current frame is unchanged; the new value appears in the next frame. Change clk_div 3 -> 0 mid-frame: the next bck half-period is 1 clk, with no stall.
6. Assert reset for 1 clk at bit_cnt = 10:
   - bck, ws, din and frame_strobe are 0 on the next clk.
   - After release, the frame restarts with frame_strobe on the first falling event.
